// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit serial receiver: FSM encoding,
// data width and the oversample divider computation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic int tick_div(
        input int clk_hz,
        input int baud,
        input int os
    );
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider; clr restarts the phase so ticks line up
// with the detected start edge.
module uart_rx_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling.
// Define UART_RX_PARITY_EN to add a parity bit and the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600,
    parameter int OS     = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD    = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int DIV = tick_div(CLK_HZ, BAUD, OS);
    localparam int TW  = $clog2(OS);
    localparam logic [TW-1:0] T_MID  = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OS - 1);

    rx_state_t state, state_n;
    logic                 s1, rx_s;
    logic [1:0]           warm;
    logic                 armed, armed_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 valid_n, ferr_n;
    logic                 clr, tick;
`ifdef UART_RX_PARITY_EN
    logic                 pbad, pbad_n, perr_n;
`endif

    uart_rx_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    assign rx_busy = (state != ST_IDLE);

    always_comb begin
        state_n    = state;
        armed_n    = armed;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        data_n     = rx_data;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;
        clr        = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_n     = pbad;
        perr_n     = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                // warm masks the synchronizer's reset value of 1
                if (rx_s && warm[1]) begin
                    armed_n = 1'b1;
                end else if (!rx_s && armed) begin
                    state_n    = ST_START;
                    clr        = 1'b1;
                    tick_cnt_n = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + TW'(1);
                    if (tick_cnt == T_MID) begin
                        tick_cnt_n = '0;
                        state_n    = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + TW'(1);
                    if (tick_cnt == T_LAST) begin
                        tick_cnt_n = '0;
                        shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + TW'(1);
                    if (tick_cnt == T_LAST) begin
                        tick_cnt_n = '0;
                        pbad_n     = rx_s != ((^shreg) ^ ODD);
                        state_n    = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + TW'(1);
                    if (tick_cnt == T_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_n     = pbad;
                        if (rx_s && !pbad) begin
`else
                        if (rx_s) begin
`endif
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end else if (!rx_s) begin
                            ferr_n  = 1'b1;
                            armed_n = 1'b0;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b1;
            rx_s      <= 1'b1;
            warm      <= 2'b00;
            state     <= ST_IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            s1        <= rx;
            rx_s      <= s1;
            warm      <= {warm[0], 1'b1};
            state     <= state_n;
            armed     <= armed_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            pbad       <= pbad_n;
            parity_err <= perr_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (DIV=1).
// Parity cases are built in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         pcnt = 0;
`endif

    int         npass = 0, ntot = 0;
    int         vcnt = 0, fcnt = 0, both = 0;
    logic [7:0] dlog [0:63];
    longint     t_fall = 0, t_valid = 0;

    uart_rx #(
        .CLK_HZ (1600000),
        .BAUD   (100000),
        .OS     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (vcnt < 64) dlog[vcnt] = rx_data;
            vcnt++;
            t_valid = $time;
        end
        if (frame_err) fcnt++;
        if (rx_valid && frame_err) both++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pcnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int rst_bit);
        rx = 1'b0;
        t_fall = $time;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == rst_bit) begin
                repeat (6) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                chk("rst_busy", {31'd0, rx_busy}, 32'd0);
                chk("rst_data", {24'd0, rx_data}, 32'h00);
                repeat (7) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (16) @(negedge clk);
`endif
        rx = stop_b;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, f0;
        logic done, bad;
        longint lat;

        repeat (3) @(negedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // single byte and latency
        v0 = vcnt; f0 = fcnt;
        send_frame(8'hA5, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("a5_count", vcnt - v0, 1);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_ferr", fcnt - f0, 0);
        lat = (t_valid - t_fall) / 10;
        chk("a5_latency", {31'd0, (lat >= LAT - 2 && lat <= LAT)}, 32'd1);
        repeat (10) @(negedge clk);

        // back-to-back, no idle gap
        v0 = vcnt;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("b2b_count", vcnt - v0, 2);
        chk("b2b_first", {24'd0, dlog[v0]}, 32'h00);
        chk("b2b_second", {24'd0, dlog[v0+1]}, 32'hFF);
        repeat (10) @(negedge clk);

        // short glitch is a false start
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!rx_busy) done = 1'b1;
        end
        chk("glitch_idle", {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);
        chk("glitch_nopulse", (vcnt - v0) + (fcnt - f0), 0);
        send_frame(8'h3C, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("after_glitch_count", vcnt - v0, 1);
        chk("after_glitch_data", {24'd0, rx_data}, 32'h3C);
        repeat (10) @(negedge clk);

        // stop bit low, line stays low
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h55, 1'b0, -1);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rx_busy) bad = 1'b1;
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_count", fcnt - f0, 1);
        chk("ferr_novalid", vcnt - v0, 0);
        chk("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
        chk("ferr_no_restart", {31'd0, bad}, 32'd0);

        // reset in the middle of a frame
        v0 = vcnt; f0 = fcnt;
        send_frame(8'hC3, 1'b1, 4);
        repeat (20) @(negedge clk);
        chk("rst_mid_novalid", vcnt - v0, 0);
        chk("rst_mid_noferr", fcnt - f0, 0);
        send_frame(8'h81, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("post_rst_count", vcnt - v0, 1);
        chk("post_rst_data", {24'd0, rx_data}, 32'h81);
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt; f0 = pcnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("par_bad_perr", pcnt - f0, 1);
        chk("par_bad_novalid", vcnt - v0, 0);
        par_flip = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h07, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("par_ok_count", vcnt - v0, 1);
        chk("par_ok_data", {24'd0, rx_data}, 32'h07);
        chk("par_ok_noperr", pcnt - f0, 1);
`endif

        chk("valid_ferr_exclusive", both, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter OS, default 16, oversample ticks per bit; even, at least 4.
REQ-004 Port clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-008 Port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 Port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 Port rx_busy  output  1  high in every state except IDLE.
REQ-011 Port parity_err  output  1  one-cycle pulse on parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_s) before any use; the synchronizer resets to 1.
REQ-013 SHALL produce an oversample tick every DIV = CLK_HZ/(BAUD*OS) clocks, integer floor, minimum 1.
REQ-014 SHALL use states IDLE, START, DATA, (PARITY), STOP, with the encoding taken from the package.
REQ-015 IDLE: when armed and rx_s==0, SHALL go to START and clear both the tick divider and the tick counter.
- Armed is set when rx_s==1 is seen in IDLE.
- A line held low never retriggers.
REQ-016 START: at tick OS/2, SHALL sample rx_s.
- 1 → false start; return to IDLE with no output pulse.
- 0 → go to DATA and clear the tick counter.
REQ-017 DATA: every OS ticks, SHALL shift rx_s into the shift register MSB, with a right shift.
- After the 8th bit, go to STOP (or PARITY when enabled).
- A 3-bit counter wraps 7→0 on exit.
REQ-018 STOP: after OS ticks, SHALL sample rx_s.
- 1 → rx_data <= shift register, rx_valid=1 for one clock.
- 0 → frame_err=1 for one clock, rx_data unchanged, armed cleared.
- In both cases, go to IDLE.
REQ-019 rx_valid and frame_err SHALL never assert in the same cycle.
REQ-020 rx_valid SHALL assert 2 + DIV*(OS/2 + 9*OS) clocks (±DIV) after the falling rx edge.
REQ-021 SHALL have no flow control: a byte not captured on its rx_valid pulse is lost, and reception continues regardless.

Reset
REQ-022 Reset SHALL force the following values, and SHALL abort any frame in progress without emitting a pulse.
- State IDLE, armed=0, counters 0.
- rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, rx_busy=0.
REQ-023 Reset asserted mid-frame and then released with rx low SHALL NOT start a frame until rx_s has returned high.

Configuration
REQ-024 Macro UART_RX_PARITY_EN SHALL, when defined:
- Add parameter ODD (default 0) and the PARITY state between DATA and STOP.
- Sample parity after OS ticks.
- On mismatch, pulse parity_err together with the outcome of the stop-bit check, and suppress rx_valid.
REQ-025 Without UART_RX_PARITY_EN, the block SHALL be pure 8N1 and the parity_err port SHALL be absent.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum/localparams, DATA_BITS=8, and the tick-divider computation function.
REQ-027 The oversample tick divider SHALL be sub-module uart_rx_tick_gen (inputs clk, reset, clr; output tick).
- clr zeroes the divider so that tick phase aligns to the start edge.

Verification (CLK_HZ=1600000, BAUD=100000, OS=16 → DIV=1, 16 clk/bit)
REQ-028 Send 8'hA5 framed 8N1 → rx_valid pulses once with rx_data=8'hA5, 154±1 clk after the falling edge; frame_err stays 0.
REQ-029 Send 8'h00, then 8'hFF back-to-back with no idle gap → two rx_valid pulses, with data 00 then FF.
REQ-030 Low glitch of 4 clk on an idle line → no pulse, rx_busy returns 0 within 10 clk, next frame 8'h3C is received correctly.
REQ-031 Send 8'h55 with the stop bit forced low, line held low 40 clk, then high → frame_err pulses once, rx_data keeps its prior value, no restart while low.
REQ-032 Assert reset for 2 clk during bit 4 of 8'hC3, then send 8'h81 → no output for C3, rx_valid with 8'h81.
REQ-033 With UART_RX_PARITY_EN, ODD=0, send 8'h07 with parity bit 0 → parity_err pulses, rx_valid absent; with parity bit 1 → rx_valid with 8'h07.
